// File: rtl/spin_ctrl.sv
// LED-spinner round sequencer: gathers rng entropy while idle, spins fast laps,
// decelerates onto a captured random target, then holds the result.
module spin_ctrl #(
  parameter int unsigned NUM_LEDS     = 8,
  parameter int unsigned PERIOD_START = 2,
  parameter int unsigned PERIOD_INC   = 1,
  parameter int unsigned PERIOD_MAX   = 255,
  parameter int unsigned MIN_ROUNDS   = 3,
  parameter int unsigned HOLD_TICKS   = 100
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       tick_i,
  input  logic       start_i,
  input  logic [3:0] lfsr_i,
  output logic       rng_en_o,
  output logic [3:0] led_pos_o,
  output logic [3:0] target_o,
  output logic       busy_o,
  output logic       done_o
);

  typedef enum logic [1:0] {StIdle, StSpin, StSlow, StShow} state_e;

  localparam logic [3:0]  LastPos     = 4'(NUM_LEDS - 1);
  localparam logic [3:0]  MinRounds   = 4'(MIN_ROUNDS);
  localparam logic [7:0]  PeriodStart = 8'(PERIOD_START);
  localparam logic [8:0]  PeriodMax   = 9'(PERIOD_MAX);
  localparam logic [8:0]  PeriodInc   = 9'(PERIOD_INC);
  localparam logic [15:0] HoldLast    = 16'(HOLD_TICKS - 1);

  state_e      state_q, state_d;
  logic [3:0]  pos_q, pos_d;
  logic [3:0]  target_q, target_d;
  logic [3:0]  laps_q, laps_d;
  logic [7:0]  period_q, period_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [15:0] hold_q, hold_d;
  logic        done_q, done_d;

  logic       step;
  logic       wrap;
  logic [3:0] pos_next;
  logic [8:0] period_sum;

  always_comb begin
    step       = tick_i && (cnt_q == period_q - 8'd1);
    wrap       = (pos_q == LastPos);
    pos_next   = wrap ? 4'd0 : pos_q + 4'd1;
    // 9-bit sum so saturation works even when period + inc exceeds 255
    period_sum = {1'b0, period_q} + PeriodInc;
  end

  always_comb begin
    state_d  = state_q;
    pos_d    = pos_q;
    target_d = target_q;
    laps_d   = laps_q;
    period_d = period_q;
    cnt_d    = cnt_q;
    hold_d   = hold_q;
    done_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          target_d = 4'(32'(lfsr_i) % NUM_LEDS);
          period_d = PeriodStart;
          cnt_d    = 8'd0;
          laps_d   = 4'd0;
          state_d  = StSpin;
        end
      end
      StSpin: begin
        if (step) begin
          cnt_d = 8'd0;
          pos_d = pos_next;
          if (wrap) begin
            laps_d = laps_q + 4'd1;
            if (laps_q + 4'd1 == MinRounds) state_d = StSlow;
          end
        end else if (tick_i) begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StSlow: begin
        if (step) begin
          cnt_d    = 8'd0;
          pos_d    = pos_next;
          period_d = (period_sum > PeriodMax) ? PeriodMax[7:0] : period_sum[7:0];
          if (pos_next == target_q) begin
            state_d = StShow;
            done_d  = 1'b1;
            hold_d  = 16'd0;
          end
        end else if (tick_i) begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StShow: begin
        if (tick_i) begin
          if (hold_q == HoldLast) state_d = StIdle;
          else                    hold_d  = hold_q + 16'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      pos_q    <= 4'd0;
      target_q <= 4'd0;
      laps_q   <= 4'd0;
      period_q <= PeriodStart;
      cnt_q    <= 8'd0;
      hold_q   <= 16'd0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pos_q    <= pos_d;
      target_q <= target_d;
      laps_q   <= laps_d;
      period_q <= period_d;
      cnt_q    <= cnt_d;
      hold_q   <= hold_d;
      done_q   <= done_d;
    end
  end

  assign rng_en_o  = tick_i && (state_q == StIdle);
  assign led_pos_o = pos_q;
  assign target_o  = target_q;
  assign busy_o    = (state_q != StIdle);
  assign done_o    = done_q;

endmodule
